// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared definitions for the VGA raster timing controller.
//   - phase_e      : per-axis raster phase (visible, front porch, sync, back porch)
//   - DEF_*        : default 640x480@60 timing constants
//   - axis_total   : line/frame length derivation from the four phase lengths
//   - h_total/v_total : named wrappers of axis_total for each axis
//   - phase_after  : successor phase, skipping zero-length phases
//   No ports (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_VISIBLE = 2'd0,
        PH_FRONT   = 2'd1,
        PH_SYNC    = 2'd2,
        PH_BACK    = 2'd3
    } phase_e;

    // 640x480@60 Hz, 25.175 MHz pixel clock
    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_CNT_W     = 10;

    function automatic int unsigned axis_total(
        input int unsigned vis,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return vis + front + sync + back;
    endfunction

    function automatic int unsigned h_total(
        input int unsigned vis,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return axis_total(vis, front, sync, back);
    endfunction

    function automatic int unsigned v_total(
        input int unsigned vis,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return axis_total(vis, front, sync, back);
    endfunction

    localparam int unsigned DEF_H_TOTAL =
        h_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int unsigned DEF_V_TOTAL =
        v_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    // Successor of a phase in the raster sequence. Empty phases are skipped
    // by chaining the checks in sequence order; the visible phase is assumed
    // non-empty so the chain always terminates there.
    function automatic phase_e phase_after(
        input phase_e      cur,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        phase_e nxt;
        nxt = PH_VISIBLE;
        case (cur)
            PH_VISIBLE: nxt = PH_FRONT;
            PH_FRONT:   nxt = PH_SYNC;
            PH_SYNC:    nxt = PH_BACK;
            default:    nxt = PH_VISIBLE;
        endcase
        if (nxt == PH_FRONT && front == 0) nxt = PH_SYNC;
        if (nxt == PH_SYNC  && sync  == 0) nxt = PH_BACK;
        if (nxt == PH_BACK  && back  == 0) nxt = PH_VISIBLE;
        return nxt;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   One raster axis: position counter, phase FSM and sync decode.
//   Ports:
//     clk_i      in   clock
//     rst_i      in   synchronous active-high reset
//     en_i       in   advance the counter on this clock edge
//     cnt_o      out  current position, 0 .. TOTAL-1
//     sync_o     out  registered sync, SYNC_POL level while in the sync phase
//     vis_next_o out  next-state "in visible phase" (for aligned registering)
//     wrap_o     out  this edge moves the counter from TOTAL-1 to 0
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned LEN_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned LEN_FRONT   = DEF_H_FRONT,
    parameter int unsigned LEN_SYNC    = DEF_H_SYNC,
    parameter int unsigned LEN_BACK    = DEF_H_BACK,
    parameter logic        SYNC_POL    = 1'b0,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sync_o,
    output logic             vis_next_o,
    output logic             wrap_o
);

    localparam int unsigned TOTAL =
        axis_total(LEN_VISIBLE, LEN_FRONT, LEN_SYNC, LEN_BACK);

    // Last count of each phase. An empty phase shares its end with the
    // preceding one, but the FSM never sits in an empty phase.
    localparam logic [CNT_W-1:0] END_VIS   = CNT_W'(LEN_VISIBLE - 1);
    localparam logic [CNT_W-1:0] END_FRONT = CNT_W'(LEN_VISIBLE + LEN_FRONT - 1);
    localparam logic [CNT_W-1:0] END_SYNC  = CNT_W'(LEN_VISIBLE + LEN_FRONT + LEN_SYNC - 1);
    localparam logic [CNT_W-1:0] END_LAST  = CNT_W'(TOTAL - 1);

    localparam phase_e AFTER_VIS   = phase_after(PH_VISIBLE, LEN_FRONT, LEN_SYNC, LEN_BACK);
    localparam phase_e AFTER_FRONT = phase_after(PH_FRONT,   LEN_FRONT, LEN_SYNC, LEN_BACK);
    localparam phase_e AFTER_SYNC  = phase_after(PH_SYNC,    LEN_FRONT, LEN_SYNC, LEN_BACK);
    localparam phase_e AFTER_BACK  = phase_after(PH_BACK,    LEN_FRONT, LEN_SYNC, LEN_BACK);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    phase_e           phase_q, phase_d;
    logic             sync_q, sync_d;
    logic             last;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        last    = (cnt_q == END_LAST);

        if (en_i) begin
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
            case (phase_q)
                PH_VISIBLE: if (cnt_q == END_VIS)   phase_d = AFTER_VIS;
                PH_FRONT:   if (cnt_q == END_FRONT) phase_d = AFTER_FRONT;
                PH_SYNC:    if (cnt_q == END_SYNC)  phase_d = AFTER_SYNC;
                PH_BACK:    if (last)               phase_d = AFTER_BACK;
                default:    phase_d = PH_VISIBLE;
            endcase
        end

        // Sync is registered from the next phase so it lands on the same
        // edge as the count it belongs to.
        sync_d = (phase_d == PH_SYNC) ? SYNC_POL : !SYNC_POL;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= PH_VISIBLE;
            sync_q  <= !SYNC_POL;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            sync_q  <= sync_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign sync_o     = sync_q;
    assign vis_next_o = (phase_d == PH_VISIBLE);
    assign wrap_o     = en_i && last;

endmodule

// File: rtl/vga_sync_ctrl.sv
// -----------------------------------------------------------------------------
// vga_sync_ctrl
//   VGA raster timing controller: horizontal and vertical axis counters with
//   registered sync, blanking, coordinates and line/frame strobes.
//   Ports:
//     clk          in   system clock
//     reset        in   synchronous active-high reset
//     pix_en       in   pixel tick; everything advances only on these edges
//     hsync/vsync  out  sync at SYNC_POL level during the sync phase
//     video_on     out  both axes in their visible phase
//     pix_x/pix_y  out  current raster position
//     line_start   out  one-clk pulse after the edge where pix_x wrapped to 0
//     frame_start  out  one-clk pulse after the edge where (x,y) wrapped to (0,0)
//     frame_cnt    out  8-bit wrapping frame counter (only with
//                       VGA_SYNC_FRAME_CNT_EN defined)
//   Build option: `define VGA_SYNC_FRAME_CNT_EN to add the frame_cnt output.
// -----------------------------------------------------------------------------
module vga_sync_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter logic        SYNC_POL  = 1'b0,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_start,
`ifdef VGA_SYNC_FRAME_CNT_EN
    output logic             frame_start,
    output logic [7:0]       frame_cnt
`else
    output logic             frame_start
`endif
);

    logic h_vis_next, v_vis_next;
    logic h_wrap, v_wrap;

    logic video_on_q, video_on_d;
    logic line_start_q, frame_start_q;

    vga_axis_counter #(
        .LEN_VISIBLE (H_VISIBLE),
        .LEN_FRONT   (H_FRONT),
        .LEN_SYNC    (H_SYNC),
        .LEN_BACK    (H_BACK),
        .SYNC_POL    (SYNC_POL),
        .CNT_W       (CNT_W)
    ) u_h_axis (
        .clk_i      (clk),
        .rst_i      (reset),
        .en_i       (pix_en),
        .cnt_o      (pix_x),
        .sync_o     (hsync),
        .vis_next_o (h_vis_next),
        .wrap_o     (h_wrap)
    );

    // The vertical axis steps once per completed line; h_wrap already
    // includes pix_en, so both axes wrap together on the same edge.
    vga_axis_counter #(
        .LEN_VISIBLE (V_VISIBLE),
        .LEN_FRONT   (V_FRONT),
        .LEN_SYNC    (V_SYNC),
        .LEN_BACK    (V_BACK),
        .SYNC_POL    (SYNC_POL),
        .CNT_W       (CNT_W)
    ) u_v_axis (
        .clk_i      (clk),
        .rst_i      (reset),
        .en_i       (h_wrap),
        .cnt_o      (pix_y),
        .sync_o     (vsync),
        .vis_next_o (v_vis_next),
        .wrap_o     (v_wrap)
    );

    // Blanking is registered from both axes' next phase so it stays aligned
    // with the coordinates rather than lagging them by a cycle.
    always_comb begin
        video_on_d = video_on_q;
        if (pix_en) video_on_d = h_vis_next && v_vis_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            video_on_q    <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            video_on_q    <= video_on_d;
            // Strobes: set only on the edge that wraps, cleared on every other
            // clock regardless of pix_en.
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
        end
    end

    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (v_wrap) frame_cnt_d = frame_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) frame_cnt_q <= '0;
        else       frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_ctrl
//   Directed bench for vga_sync_ctrl. Four instances share clk/reset/pix_en:
//     d  : default 640x480 timing, active-low sync
//     s0 : small raster H 8/2/3/2 (15), V 4/1/2/1 (8), active-low sync
//     s1 : same small raster, active-high sync
//     z  : zero-porch raster H 4/0/2/0 (6), V 2/0/1/1 (4), active-low sync
//   Honours VGA_SYNC_FRAME_CNT_EN for the frame_cnt port.
// -----------------------------------------------------------------------------
module tb_vga_sync_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic       d_hs, d_vs, d_von, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s0_hs, s0_vs, s0_von, s0_ls, s0_fs;
    logic [3:0] s0_x, s0_y;
    logic       s1_hs, s1_vs, s1_von, s1_ls, s1_fs;
    logic [3:0] s1_x, s1_y;
    logic       z_hs, z_vs, z_von, z_ls, z_fs;
    logic [2:0] z_x, z_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] d_fc, s0_fc, s1_fc, z_fc;
`endif

    vga_sync_ctrl u_d (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
        .pix_x(d_x), .pix_y(d_y), .line_start(d_ls),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .frame_start(d_fs), .frame_cnt(d_fc)
`else
        .frame_start(d_fs)
`endif
    );

    vga_sync_ctrl #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(1'b0), .CNT_W(4)
    ) u_s0 (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(s0_hs), .vsync(s0_vs), .video_on(s0_von),
        .pix_x(s0_x), .pix_y(s0_y), .line_start(s0_ls),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .frame_start(s0_fs), .frame_cnt(s0_fc)
`else
        .frame_start(s0_fs)
`endif
    );

    vga_sync_ctrl #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(1'b1), .CNT_W(4)
    ) u_s1 (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(s1_hs), .vsync(s1_vs), .video_on(s1_von),
        .pix_x(s1_x), .pix_y(s1_y), .line_start(s1_ls),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .frame_start(s1_fs), .frame_cnt(s1_fc)
`else
        .frame_start(s1_fs)
`endif
    );

    vga_sync_ctrl #(
        .H_VISIBLE(4), .H_FRONT(0), .H_SYNC(2), .H_BACK(0),
        .V_VISIBLE(2), .V_FRONT(0), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b0), .CNT_W(3)
    ) u_z (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(z_hs), .vsync(z_vs), .video_on(z_von),
        .pix_x(z_x), .pix_y(z_y), .line_start(z_ls),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .frame_start(z_fs), .frame_cnt(z_fc)
`else
        .frame_start(z_fs)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one clock edge, sample 1 time unit later.
    task automatic cyc(input logic rst, input logic en);
        reset  = rst;
        pix_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b1);
    endtask

    // Expected state of the small and zero-porch instances after k pix_en
    // ticks since reset. 'fresh' means the previous edge was a tick.
    task automatic chk_small(input int unsigned k, input logic fresh);
        int unsigned sx, sy, zx, zy;
        logic s_hs, s_vs, s_von, s_ls, s_fs;
        logic e_hs, e_vs, e_von, e_ls, e_fs;
        sx    = k % 15;
        sy    = (k / 15) % 8;
        zx    = k % 6;
        zy    = (k / 6) % 4;
        s_hs  = !(sx >= 10 && sx <= 12);
        s_vs  = !(sy == 5 || sy == 6);
        s_von = (sx < 8) && (sy < 4);
        s_ls  = fresh && (k > 0) && (sx == 0);
        s_fs  = s_ls && (sy == 0);
        e_hs  = !(zx >= 4);
        e_vs  = !(zy == 2);
        e_von = (zx < 4) && (zy < 2);
        e_ls  = fresh && (k > 0) && (zx == 0);
        e_fs  = e_ls && (zy == 0);
        chk("s0_x", 32'(s0_x), sx);
        chk("s0_y", 32'(s0_y), sy);
        chk("s0_hsync", 32'(s0_hs), 32'(s_hs));
        chk("s0_vsync", 32'(s0_vs), 32'(s_vs));
        chk("s0_video_on", 32'(s0_von), 32'(s_von));
        chk("s0_line_start", 32'(s0_ls), 32'(s_ls));
        chk("s0_frame_start", 32'(s0_fs), 32'(s_fs));
        chk("s1_x", 32'(s1_x), sx);
        chk("s1_y", 32'(s1_y), sy);
        chk("s1_hsync_inv", 32'(s1_hs), 32'(!s_hs));
        chk("s1_vsync_inv", 32'(s1_vs), 32'(!s_vs));
        chk("s1_video_on", 32'(s1_von), 32'(s_von));
        chk("s1_line_start", 32'(s1_ls), 32'(s_ls));
        chk("s1_frame_start", 32'(s1_fs), 32'(s_fs));
        chk("z_x", 32'(z_x), zx);
        chk("z_y", 32'(z_y), zy);
        chk("z_hsync", 32'(z_hs), 32'(e_hs));
        chk("z_vsync", 32'(z_vs), 32'(e_vs));
        chk("z_video_on", 32'(z_von), 32'(e_von));
        chk("z_line_start", 32'(z_ls), 32'(e_ls));
        chk("z_frame_start", 32'(z_fs), 32'(e_fs));
    endtask

    initial begin
        // Reset held with pix_en high: reset must win.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk("rst_x", 32'(d_x), 0);
        chk("rst_y", 32'(d_y), 0);
        chk("rst_video_on", 32'(d_von), 1);
        chk("rst_hsync", 32'(d_hs), 1);
        chk("rst_vsync", 32'(d_vs), 1);
        chk("rst_line_start", 32'(d_ls), 0);
        chk("rst_frame_start", 32'(d_fs), 0);
        chk_small(0, 1'b0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("rst_frame_cnt", 32'(d_fc), 0);
`endif

        // First line of the default raster.
        run(639);
        chk("x639", 32'(d_x), 639);
        chk("x639_video_on", 32'(d_von), 1);
        chk("x639_hsync", 32'(d_hs), 1);
        run(1);
        chk("x640", 32'(d_x), 640);
        chk("x640_video_on", 32'(d_von), 0);
        chk("x640_hsync", 32'(d_hs), 1);
        run(15);
        chk("x655_hsync", 32'(d_hs), 1);
        run(1);
        chk("x656", 32'(d_x), 656);
        chk("x656_hsync", 32'(d_hs), 0);
        run(95);
        chk("x751", 32'(d_x), 751);
        chk("x751_hsync", 32'(d_hs), 0);
        run(1);
        chk("x752_hsync", 32'(d_hs), 1);
        run(47);
        chk("x799", 32'(d_x), 799);
        chk("x799_y", 32'(d_y), 0);
        chk("x799_line_start", 32'(d_ls), 0);
        chk("x799_video_on", 32'(d_von), 0);
        run(1);
        chk("wrap_x", 32'(d_x), 0);
        chk("wrap_y", 32'(d_y), 1);
        chk("wrap_line_start", 32'(d_ls), 1);
        chk("wrap_frame_start", 32'(d_fs), 0);
        chk("wrap_video_on", 32'(d_von), 1);
        chk("wrap_vsync", 32'(d_vs), 1);
        run(1);
        chk("x1_x", 32'(d_x), 1);
        chk("x1_line_start", 32'(d_ls), 0);

        // pix_en low: everything holds.
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("hold_x", 32'(d_x), 1);
        chk("hold_y", 32'(d_y), 1);
        chk("hold_line_start", 32'(d_ls), 0);

        // Reset mid-line while in hsync, together with pix_en.
        run(699);
        chk("pre_rst_x", 32'(d_x), 700);
        chk("pre_rst_hsync", 32'(d_hs), 0);
        chk("pre_rst_video_on", 32'(d_von), 0);
        cyc(1'b1, 1'b1);
        chk("mid_rst_x", 32'(d_x), 0);
        chk("mid_rst_y", 32'(d_y), 0);
        chk("mid_rst_video_on", 32'(d_von), 1);
        chk("mid_rst_hsync", 32'(d_hs), 1);
        chk("mid_rst_vsync", 32'(d_vs), 1);
        chk("mid_rst_line_start", 32'(d_ls), 0);
        chk("mid_rst_frame_start", 32'(d_fs), 0);
        chk_small(0, 1'b0);

        // One full small frame with pix_en held high.
        for (int unsigned k = 1; k <= 120; k++) begin
            cyc(1'b0, 1'b1);
            chk_small(k, 1'b1);
        end
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("s0_frame_cnt_1", 32'(s0_fc), 1);
        chk("z_frame_cnt_5", 32'(z_fc), 5);
`endif

        // Second frame with pix_en 1-of-4: same per-tick sequence, frozen between.
        for (int unsigned k = 121; k <= 240; k++) begin
            for (int unsigned j = 0; j < 3; j++) begin
                cyc(1'b0, 1'b0);
                chk_small(k - 1, 1'b0);
            end
            cyc(1'b0, 1'b1);
            chk_small(k, 1'b1);
        end
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("s0_frame_cnt_2", 32'(s0_fc), 2);
        chk("z_frame_cnt_10", 32'(z_fc), 10);

        // 257 small frames from reset: counter wraps 255 -> 0 -> 1.
        cyc(1'b1, 1'b0);
        chk("fc_rst", 32'(s0_fc), 0);
        run(120 * 257);
        chk("s0_frame_cnt_257", 32'(s0_fc), 1);
        chk("s1_frame_cnt_257", 32'(s1_fc), 1);
        chk("z_frame_cnt_1285", 32'(z_fc), 5);
        chk("d_frame_cnt_none", 32'(d_fc), 0);
        chk("s0_x_257", 32'(s0_x), 0);
        chk("s0_y_257", 32'(s0_y), 0);
        chk("s0_frame_start_257", 32'(s0_fs), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
